// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - convolution control sequencer: filter load with zero-column skew, image stream, drain per filter.
// Optional CONV_STRIDE_EN adds cmd_stride and gates valid_pixel on row/column stride phase.
module conv_sequencer #(
   parameter int ARRAY_DIM = 16,
   parameter int DIM_W     = 12,
   parameter int ADDR_W    = 20,
   parameter int FS_W      = 4,
   parameter int FN_W      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_filter_offset,
   input  logic [ADDR_W-1:0] cmd_img_offset,
   input  logic [DIM_W-1:0]  cmd_img_height,
   input  logic [DIM_W-1:0]  cmd_img_width,
   input  logic [FS_W-1:0]   cmd_filter_size,
   input  logic [FN_W-1:0]   cmd_filter_num,
`ifdef CONV_STRIDE_EN
   input  logic [1:0]        cmd_stride,
`endif
   output logic [DIM_W-1:0]  row,
   output logic [DIM_W-1:0]  column,
   output logic [DIM_W-1:0]  width,
   output logic [ADDR_W-1:0] offset,
   output logic [FS_W-1:0]   filter_size,
   output logic              zero,
   output logic              load_en,
   input  logic              scratch_rdy,
   output logic              shift_en,
   output logic              store_en,
   output logic              valid_pixel,
   output logic              out_last,
   input  logic              in_last,
   output logic              conv_done,
   output logic              cmd_err
);

   localparam int CW = (DIM_W > FS_W) ? DIM_W : FS_W;
   localparam int PW = FN_W + FS_W + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_FLT_LOAD, S_FLT_ZERO, S_FLT_SAVE, S_IMG_LOAD, S_DRAIN, S_DONE
   } state_t;

   state_t r_state, w_state_nxt;

   logic [DIM_W-1:0]  r_row, r_column, r_h, r_w;
   logic [FN_W-1:0]   r_filter_count, r_fn;
   logic [FS_W-1:0]   r_fs;
   logic [ADDR_W-1:0] r_flt_off, r_img_off;
   logic              r_conv_done, r_cmd_err;

   logic              w_cmd_fire, w_cmd_bad;
   logic [DIM_W-1:0]  w_fs_d, w_max_row, w_max_col, w_flt_row;
   logic [PW-1:0]     w_k, w_prod;
   logic              w_col_last_flt, w_col_last_img, w_row_last_img, w_last_filter;
   logic              w_phase_ok;

`ifdef CONV_STRIDE_EN
   logic [1:0] r_stride, r_row_ph, r_col_ph;
   assign w_phase_ok = (r_row_ph == 2'd0) && (r_col_ph == 2'd0);
`else
   assign w_phase_ok = 1'b1;
`endif

   assign w_cmd_fire = cmd_valid && (r_state == S_IDLE);
   assign w_cmd_bad  = (CW'(cmd_img_height) <= CW'(cmd_filter_size)) ||
                       (CW'(cmd_img_width)  <= CW'(cmd_filter_size)) ||
                       (32'(cmd_filter_size) >= 32'(ARRAY_DIM));

   assign w_fs_d    = DIM_W'(r_fs);
   assign w_max_row = r_h - w_fs_d;
   assign w_max_col = r_w - w_fs_d;
   // Filter f occupies K consecutive scratchpad rows starting at f*K.
   assign w_k       = PW'(r_fs) + PW'(1);
   assign w_prod    = PW'(r_filter_count) * w_k;
   assign w_flt_row = DIM_W'(w_prod);

   assign w_col_last_flt = (32'(r_column) == 32'(ARRAY_DIM - 1));
   assign w_col_last_img = (r_column == r_w - DIM_W'(1));
   assign w_row_last_img = (r_row == w_max_row - DIM_W'(1));
   assign w_last_filter  = (r_filter_count == r_fn);

   assign column      = r_column;
   assign filter_size = r_fs;
   assign conv_done   = r_conv_done;
   assign cmd_err     = r_cmd_err;

   always_comb begin
      w_state_nxt = r_state;
      cmd_ready   = 1'b0;
      zero        = 1'b1;
      load_en     = 1'b0;
      shift_en    = 1'b0;
      store_en    = 1'b0;
      valid_pixel = 1'b0;
      out_last    = 1'b0;
      row         = r_row;
      width       = '0;
      offset      = '0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid && !w_cmd_bad) w_state_nxt = S_FLT_LOAD;
         end
         S_FLT_LOAD: begin
            width    = w_fs_d;
            offset   = r_flt_off;
            row      = w_flt_row;
            load_en  = 1'b1;
            zero     = (r_column > w_fs_d);
            shift_en = scratch_rdy;
            if (scratch_rdy) w_state_nxt = w_col_last_flt ? S_FLT_SAVE : S_FLT_ZERO;
         end
         S_FLT_ZERO: begin
            width       = w_fs_d;
            offset      = r_flt_off;
            row         = w_flt_row;
            load_en     = 1'b1;
            shift_en    = 1'b1;
            w_state_nxt = S_FLT_LOAD;
         end
         S_FLT_SAVE: begin
            width       = r_w;
            offset      = r_img_off;
            store_en    = 1'b1;
            w_state_nxt = S_IMG_LOAD;
         end
         S_IMG_LOAD: begin
            width       = r_w;
            offset      = r_img_off;
            zero        = 1'b0;
            load_en     = 1'b1;
            shift_en    = scratch_rdy;
            valid_pixel = (r_column < w_max_col) && (r_row < w_max_row) && w_phase_ok;
            if (scratch_rdy && w_col_last_img && w_row_last_img) begin
               out_last    = 1'b1;
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            width    = r_w;
            offset   = r_img_off;
            shift_en = 1'b1;
            if (in_last) w_state_nxt = w_last_filter ? S_DONE : S_FLT_LOAD;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_row          <= '0;
         r_column       <= '0;
         r_filter_count <= '0;
         r_h            <= '0;
         r_w            <= '0;
         r_fs           <= '0;
         r_fn           <= '0;
         r_flt_off      <= '0;
         r_img_off      <= '0;
         r_conv_done    <= 1'b0;
         r_cmd_err      <= 1'b0;
`ifdef CONV_STRIDE_EN
         r_stride       <= '0;
         r_row_ph       <= '0;
         r_col_ph       <= '0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_conv_done <= (r_state == S_DRAIN) && in_last && w_last_filter;
         r_cmd_err   <= w_cmd_fire && w_cmd_bad;
         case (r_state)
            S_IDLE: begin
               if (w_cmd_fire) begin
                  r_flt_off      <= cmd_filter_offset;
                  r_img_off      <= cmd_img_offset;
                  r_h            <= cmd_img_height;
                  r_w            <= cmd_img_width;
                  r_fs           <= cmd_filter_size;
                  r_fn           <= cmd_filter_num;
                  r_filter_count <= '0;
                  r_row          <= '0;
                  r_column       <= '0;
`ifdef CONV_STRIDE_EN
                  r_stride       <= cmd_stride;
`endif
               end
            end
            S_FLT_LOAD: begin
               if (scratch_rdy) r_column <= w_col_last_flt ? '0 : r_column + DIM_W'(1);
            end
            S_FLT_SAVE: begin
               r_row    <= '0;
               r_column <= '0;
`ifdef CONV_STRIDE_EN
               r_row_ph <= '0;
               r_col_ph <= '0;
`endif
            end
            S_IMG_LOAD: begin
               if (scratch_rdy && !w_col_last_img) begin
                  r_column <= r_column + DIM_W'(1);
`ifdef CONV_STRIDE_EN
                  r_col_ph <= (r_col_ph == r_stride) ? 2'd0 : r_col_ph + 2'd1;
`endif
               end else if (scratch_rdy && !w_row_last_img) begin
                  r_row    <= r_row + DIM_W'(1);
                  r_column <= '0;
`ifdef CONV_STRIDE_EN
                  r_col_ph <= '0;
                  r_row_ph <= (r_row_ph == r_stride) ? 2'd0 : r_row_ph + 2'd1;
`endif
               end
            end
            S_DRAIN: begin
               if (in_last && !w_last_filter) begin
                  r_filter_count <= r_filter_count + FN_W'(1);
                  r_column       <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - self-checking bench for conv_sequencer against a beat-list reference model.
module tb_conv_sequencer;
   localparam int AD  = 16;
   localparam int DW  = 12;
   localparam int AW  = 20;
   localparam int FSW = 4;
   localparam int FNW = 4;
   localparam int FLT_OFF = 32'h00100;
   localparam int IMG_OFF = 32'h04000;
   localparam int K_FLT = 0, K_ZRO = 1, K_IMG = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic cmd_valid = 1'b0, cmd_ready;
   logic [AW-1:0]  cmd_filter_offset = '0, cmd_img_offset = '0;
   logic [DW-1:0]  cmd_img_height = '0, cmd_img_width = '0;
   logic [FSW-1:0] cmd_filter_size = '0;
   logic [FNW-1:0] cmd_filter_num = '0;
`ifdef CONV_STRIDE_EN
   logic [1:0]     cmd_stride = '0;
`endif
   logic [DW-1:0]  row, column, width;
   logic [AW-1:0]  offset;
   logic [FSW-1:0] filter_size;
   logic zero, load_en, shift_en, store_en, valid_pixel, out_last, conv_done, cmd_err;
   logic scratch_rdy = 1'b0, in_last = 1'b0;

   conv_sequencer #(.ARRAY_DIM(AD), .DIM_W(DW), .ADDR_W(AW), .FS_W(FSW), .FN_W(FNW)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_filter_offset(cmd_filter_offset), .cmd_img_offset(cmd_img_offset),
      .cmd_img_height(cmd_img_height), .cmd_img_width(cmd_img_width),
      .cmd_filter_size(cmd_filter_size), .cmd_filter_num(cmd_filter_num),
`ifdef CONV_STRIDE_EN
      .cmd_stride(cmd_stride),
`endif
      .row(row), .column(column), .width(width), .offset(offset), .filter_size(filter_size),
      .zero(zero), .load_en(load_en), .scratch_rdy(scratch_rdy), .shift_en(shift_en),
      .store_en(store_en), .valid_pixel(valid_pixel), .out_last(out_last), .in_last(in_last),
      .conv_done(conv_done), .cmd_err(cmd_err)
   );

   typedef struct { int kind; int row; int col; bit flag; bit last; } beat_t;
   beat_t exp_q[$];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input int h, input int w, input int fs, input int fn, input int stride);
      @(posedge clk); #1;
      cmd_filter_offset = AW'(FLT_OFF);
      cmd_img_offset    = AW'(IMG_OFF);
      cmd_img_height    = DW'(h);
      cmd_img_width     = DW'(w);
      cmd_filter_size   = FSW'(fs);
      cmd_filter_num    = FNW'(fn);
`ifdef CONV_STRIDE_EN
      cmd_stride        = 2'(stride - 1);
`else
      if (stride != 1) $display("stride %0d ignored in this build", stride);
`endif
      cmd_valid = 1'b1;
      chk("cmd_ready_idle", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // Expected shift beats: per filter, AD load columns with a zero column between each,
   // then the image raster over max_row rows of W columns.
   task automatic build_model(input int h, input int w, input int fs, input int fn, input int s);
      int maxr, maxc;
      maxr = h - fs;
      maxc = w - fs;
      exp_q.delete();
      for (int f = 0; f <= fn; f++) begin
         for (int c = 0; c < AD; c++) begin
            exp_q.push_back('{K_FLT, (f * (fs + 1)) % (1 << DW), c, (c > fs), 1'b0});
            if (c < AD - 1) exp_q.push_back('{K_ZRO, 0, c + 1, 1'b1, 1'b0});
         end
         for (int r = 0; r < maxr; r++)
            for (int c = 0; c < w; c++)
               exp_q.push_back('{K_IMG, r, c,
                                 (c < maxc) && (r % s == 0) && (c % s == 0),
                                 (r == maxr - 1) && (c == w - 1)});
      end
   endtask

   task automatic run_conv(input int h, input int w, input int fs, input int fn, input int s,
                           input int rdy_mode, output int vp_cnt);
      int cyc, stores, dones, drained, last_in_cyc;
      bit finished, drain;
      beat_t e;
      vp_cnt = 0; cyc = 0; stores = 0; dones = 0; drained = 0; last_in_cyc = -10; finished = 0;
      build_model(h, w, fs, fn, s);
      send_cmd(h, w, fs, fn, s);
      chk("cmd_err_valid_cmd", cmd_err, 0);
      while (!finished && cyc < 20000) begin
         drain = shift_en && !load_en && zero;
         case (rdy_mode)
            0:       scratch_rdy = 1'b1;
            1:       scratch_rdy = (cyc % 2 == 0);
            default: scratch_rdy = 1'($urandom_range(0, 1));
         endcase
         in_last = drain ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         #1;
         chk("cmd_ready_busy", cmd_ready, 0);
         if (store_en) stores++;
         if (conv_done) begin
            dones++;
            chk("done_timing", cyc, last_in_cyc + 1);
            finished = 1;
         end
         if (shift_en && load_en) begin
            if (exp_q.size() == 0) begin
               chk("extra_beat", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               chk("beat_width", width, (e.kind == K_IMG) ? w : fs);
               chk("beat_offset", offset, (e.kind == K_IMG) ? IMG_OFF : FLT_OFF);
               chk("beat_col", column, e.col);
               if (e.kind != K_ZRO) chk("beat_row", row, e.row);
               if (e.kind == K_IMG) begin
                  chk("valid_pixel", valid_pixel, e.flag);
                  if (valid_pixel) vp_cnt++;
               end else begin
                  chk("zero", zero, e.flag);
               end
               chk("out_last", out_last, e.last);
            end
         end
         if (drain && in_last) begin
            drained++;
            if (drained == fn + 1) last_in_cyc = cyc;
         end
         @(posedge clk); #1;
         cyc++;
      end
      scratch_rdy = 1'b0;
      in_last = 1'b0;
      chk("finished_in_budget", finished, 1);
      chk("beats_left", exp_q.size(), 0);
      chk("store_count", stores, fn + 1);
      chk("done_count", dones, 1);
      #1;
      chk("done_single_pulse", conv_done, 0);
      chk("ready_after_done", cmd_ready, 1);
   endtask

   task automatic bad_cmd(input int h, input int w, input int fs);
      send_cmd(h, w, fs, 0, 1);
      chk("cmd_err_pulse", cmd_err, 1);
      chk("err_stay_idle", cmd_ready, 1);
      chk("err_no_load", load_en, 0);
      @(posedge clk); #1;
      chk("cmd_err_one_cycle", cmd_err, 0);
      chk("err_no_load2", load_en, 0);
      chk("err_idle2", cmd_ready, 1);
   endtask

   initial begin
      int vp, h, w, fs, fn, s;
      bit found;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_zero", zero, 1);
      chk("rst_load_en", load_en, 0);
      chk("rst_shift_en", shift_en, 0);
      chk("rst_store_en", store_en, 0);
      chk("rst_valid_pixel", valid_pixel, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_conv_done", conv_done, 0);
      chk("rst_cmd_err", cmd_err, 0);
      chk("rst_row", row, 0);
      chk("rst_column", column, 0);
      chk("rst_filter_size", filter_size, 0);
      rst = 1'b0;

      // 8x8, K-1=2, single filter, rdy always high then toggling
      run_conv(8, 8, 2, 0, 1, 0, vp);
      chk("vp_count_rdy1", vp, 36);
      run_conv(8, 8, 2, 0, 1, 1, vp);
      chk("vp_count_toggle", vp, 36);
      // Three filters, random rdy
      run_conv(8, 8, 2, 2, 1, 2, vp);
      chk("vp_count_3flt", vp, 108);

      // Invalid commands and the smallest valid image
      bad_cmd(2, 8, 2);
      bad_cmd(8, 2, 2);
      bad_cmd(1, 1, 3);
      run_conv(3, 3, 2, 0, 1, 2, vp);
      chk("vp_count_min", vp, 1);

      // Reset mid IMG_LOAD
      send_cmd(8, 8, 2, 0, 1);
      scratch_rdy = 1'b1;
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (load_en && width == 8 && !zero) found = 1;
         else begin @(posedge clk); #1; end
      end
      chk("reach_img_load", found, 1);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_ready", cmd_ready, 1);
      chk("midrst_row", row, 0);
      chk("midrst_col", column, 0);
      chk("midrst_done", conv_done, 0);
      in_last = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("midrst_no_done", conv_done, 0);
         chk("midrst_no_load", load_en, 0);
      end
      in_last = 1'b0;
      scratch_rdy = 1'b0;

`ifdef CONV_STRIDE_EN
      run_conv(8, 8, 2, 0, 2, 0, vp);
      chk("vp_count_stride2", vp, 9);
`endif

      // Randomized valid commands
      for (int t = 0; t < 6; t++) begin
         fs = $urandom_range(0, 3);
         h  = fs + 1 + $urandom_range(0, 4);
         w  = fs + 1 + $urandom_range(0, 4);
         fn = $urandom_range(0, 2);
`ifdef CONV_STRIDE_EN
         s  = $urandom_range(1, 4);
`else
         s  = 1;
`endif
         run_conv(h, w, fs, fn, s, 2, vp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
